// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle for the branch resolution unit.
// The slave side is the unit; the master side drives requests and consumes results.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_0;
  logic [XLEN-1:0] operand_1;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] redirect_pc;
  logic            mispredict;
  logic            illegal;

  modport slave (
    input  in_valid, funct3, operand_0, operand_1, pc, imm, pred_taken, out_ready,
    output in_ready, out_valid, taken, target, redirect_pc, mispredict, illegal
  );

  modport master (
    output in_valid, funct3, operand_0, operand_1, pc, imm, pred_taken, out_ready,
    input  in_ready, out_valid, taken, target, redirect_pc, mispredict, illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Multi-cycle RV32I branch resolver: compares operands one slice per cycle, MSB slice first,
// stopping at the first differing slice, then emits taken/target/redirect/mispredict.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);

  localparam int unsigned Chunks = XLEN / CHUNK;
  localparam int unsigned IdxW   = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(Chunks - 1);

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic [XLEN-1:0] op0_q, op1_q;
  logic [2:0]      funct3_q;
  logic            pred_q;
  logic [XLEN-1:0] pc4_q;
  logic            out_valid_q, taken_q, mispredict_q, illegal_q;
  logic [XLEN-1:0] target_q, redirect_q;

  logic [CHUNK-1:0] slice_0, slice_1;
  logic             differ, slice_lt, last_slice, cmp_taken, in_illegal;

  assign in_illegal = (bus.funct3[2:1] == 2'b01);

  always_comb begin
    slice_0 = CHUNK'(op0_q >> (32'(idx_q) * CHUNK));
    slice_1 = CHUNK'(op1_q >> (32'(idx_q) * CHUNK));
    // Flipping the sign bit on the top slice turns a signed compare into an unsigned one.
    if ((funct3_q[2:1] == 2'b10) && (idx_q == IdxTop)) begin
      slice_0[CHUNK-1] = ~slice_0[CHUNK-1];
      slice_1[CHUNK-1] = ~slice_1[CHUNK-1];
    end
    differ     = (slice_0 != slice_1);
    slice_lt   = (slice_0 < slice_1);
    last_slice = (idx_q == '0);
  end

  // Only meaningful on the resolving cycle (differ or last slice); lt is 0 when equal.
  always_comb begin
    cmp_taken = 1'b0;
    case (funct3_q)
      3'b000:         cmp_taken = !differ;
      3'b001:         cmp_taken = differ;
      3'b100, 3'b110: cmp_taken = slice_lt;
      3'b101, 3'b111: cmp_taken = !slice_lt;
      default:        cmp_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      op0_q        <= '0;
      op1_q        <= '0;
      funct3_q     <= '0;
      pred_q       <= 1'b0;
      pc4_q        <= '0;
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      target_q     <= '0;
      redirect_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op0_q    <= bus.operand_0;
            op1_q    <= bus.operand_1;
            funct3_q <= bus.funct3;
            pred_q   <= bus.pred_taken;
            pc4_q    <= bus.pc + XLEN'(4);
            target_q <= bus.pc + bus.imm;
            idx_q    <= IdxTop;
            if (in_illegal) begin
              taken_q      <= 1'b0;
              mispredict_q <= 1'b0;
              illegal_q    <= 1'b1;
              redirect_q   <= bus.pc + XLEN'(4);
              out_valid_q  <= 1'b1;
              state_q      <= StDone;
            end else begin
              state_q <= StCmp;
            end
          end
        end
        StCmp: begin
          if (differ || last_slice) begin
            taken_q      <= cmp_taken;
            mispredict_q <= (cmp_taken != pred_q);
            illegal_q    <= 1'b0;
            redirect_q   <= cmp_taken ? target_q : pc4_q;
            out_valid_q  <= 1'b1;
            state_q      <= StDone;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == StIdle) && !rst;
  assign bus.out_valid   = out_valid_q;
  assign bus.taken       = taken_q;
  assign bus.target      = target_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.illegal     = illegal_q;

endmodule
